// File: rtl/wb_arbiter_pkg.sv
// Shared widths and the buffered mul/div result entry for the writeback arbiter.
`timescale 1ns/1ps
package wb_arbiter_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;
  localparam logic [REG_ADDR_W-1:0] X0 = 5'd0;
  localparam int ENTRY_W    = REG_ADDR_W + XLEN;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       wd;
  } wb_entry_t;
endpackage

// File: rtl/wb_arbiter_sync_fifo.sv
// Small synchronous FIFO; power-of-2 depth so pointers wrap naturally.
`timescale 1ns/1ps
module sync_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 37
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       push_i,
  input  logic [W-1:0]               din_i,
  input  logic                       pop_i,
  output logic [W-1:0]               dout_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       empty_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [DEPTH-1:0][W-1:0] mem_q;
  logic [AW-1:0]           wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]           cnt_q;

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= din_i;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
    end
  end

  assign dout_o  = mem_q[rd_ptr_q];
  assign count_o = cnt_q;
  assign empty_o = (cnt_q == '0);
endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: pipeline writes win the single RF port; buffered mul/div results
// fill idle slots, with a one-cycle stall forced when the FIFO head starves.
`timescale 1ns/1ps
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  pipe_we,
  input  logic [REG_ADDR_W-1:0] pipe_rd,
  input  logic [XLEN-1:0]       pipe_wd,
  input  logic                  md_valid,
  output logic                  md_ready,
  input  logic [REG_ADDR_W-1:0] md_rd,
  input  logic [XLEN-1:0]       md_wd,
  input  logic                  iss_valid,
  input  logic [REG_ADDR_W-1:0] iss_rd,
  output logic [REG_ADDR_W-1:0] a3,
  output logic [XLEN-1:0]       wd3,
  output logic                  we3,
  output logic [31:0]           pend_mask,
  output logic                  stall_req
);
  localparam int FCW = $clog2(DEPTH+1);
  localparam int SCW = $clog2(STARVE_MAX+1);

  wb_entry_t      head, md_entry;
  logic [FCW-1:0] fifo_cnt;
  logic           fifo_empty, push, pop, pipe_hit;
  logic [SCW-1:0] starve_q, starve_d;
  logic           stall_q, stall_d;
  logic [31:0]    pend_q, pend_d;

  assign md_entry = '{rd: md_rd, wd: md_wd};
  assign md_ready = (fifo_cnt < FCW'(DEPTH));
  assign push     = md_valid & md_ready;

  // The stall cycle ignores the (held) pipe write so the head is guaranteed to drain.
  assign pipe_hit = pipe_we & (pipe_rd != X0) & ~stall_q;
  assign pop      = ~pipe_hit & ~fifo_empty;

  sync_fifo #(.DEPTH(DEPTH), .W(ENTRY_W)) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .push_i  (push),
    .din_i   (md_entry),
    .pop_i   (pop),
    .dout_o  (head),
    .count_o (fifo_cnt),
    .empty_o (fifo_empty)
  );

  always_comb begin
    we3 = 1'b0;
    a3  = X0;
    wd3 = '0;
    if (pipe_hit) begin
      we3 = 1'b1;
      a3  = pipe_rd;
      wd3 = pipe_wd;
    end else if (!fifo_empty) begin
      we3 = (head.rd != X0);
      a3  = head.rd;
      wd3 = head.wd;
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (pop || fifo_empty) starve_d = '0;
    else if (pipe_hit)     starve_d = starve_q + 1'b1;
    stall_d = (starve_d == SCW'(STARVE_MAX));
  end

  // Issue set is applied after the commit clear so a same-cycle set wins.
  always_comb begin
    pend_d = pend_q;
    if (pop && head.rd != X0)       pend_d[head.rd] = 1'b0;
    if (iss_valid && iss_rd != X0)  pend_d[iss_rd]  = 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      starve_q <= '0;
      stall_q  <= 1'b0;
      pend_q   <= '0;
    end else begin
      starve_q <= starve_d;
      stall_q  <= stall_d;
      pend_q   <= pend_d;
    end
  end

  assign pend_mask = pend_q;
  assign stall_req = stall_q;
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: reset, lone result, contention/starvation, full FIFO, x0, set/clear.
`timescale 1ns/1ps
module tb_wb_arbiter;
  logic        clk, rstn;
  logic        pipe_we, md_valid, md_ready, iss_valid, we3, stall_req;
  logic [4:0]  pipe_rd, md_rd, iss_rd, a3;
  logic [31:0] pipe_wd, md_wd, wd3, pend_mask;

  int n_cmp = 0;
  int n_err = 0;

  wb_arbiter #(.DEPTH(2), .STARVE_MAX(4)) dut (
    .clk(clk), .rstn(rstn),
    .pipe_we(pipe_we), .pipe_rd(pipe_rd), .pipe_wd(pipe_wd),
    .md_valid(md_valid), .md_ready(md_ready), .md_rd(md_rd), .md_wd(md_wd),
    .iss_valid(iss_valid), .iss_rd(iss_rd),
    .a3(a3), .wd3(wd3), .we3(we3), .pend_mask(pend_mask), .stall_req(stall_req)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: got %h want %h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic issue(input logic [4:0] rd);
    iss_valid = 1'b1; iss_rd = rd;
    tick();
    iss_valid = 1'b0; iss_rd = 5'd0;
  endtask

  initial begin
    rstn = 1'b0; pipe_we = 0; pipe_rd = 0; pipe_wd = 0;
    md_valid = 0; md_rd = 0; md_wd = 0; iss_valid = 0; iss_rd = 0;
    #1;
    chk("rst_we3", {31'd0, we3}, 32'd0);
    chk("rst_a3", {27'd0, a3}, 32'd0);
    chk("rst_wd3", wd3, 32'd0);
    chk("rst_pend", pend_mask, 32'd0);
    chk("rst_stall", {31'd0, stall_req}, 32'd0);
    chk("rst_ready", {31'd0, md_ready}, 32'd1);
    tick(); tick();
    rstn = 1'b1;
    tick();

    // Lone md result: no same-cycle bypass, commit one cycle after acceptance
    issue(5'd5);
    chk("lone_pend_set", pend_mask, 32'h0000_0020);
    md_valid = 1; md_rd = 5'd5; md_wd = 32'hDEAD_BEEF;
    #1 chk("lone_no_bypass", {31'd0, we3}, 32'd0);
    tick();
    md_valid = 0;
    #1;
    chk("lone_we3", {31'd0, we3}, 32'd1);
    chk("lone_a3", {27'd0, a3}, 32'd5);
    chk("lone_wd3", wd3, 32'hDEAD_BEEF);
    chk("lone_pend_hold", pend_mask, 32'h0000_0020);
    tick();
    chk("lone_pend_clr", pend_mask, 32'd0);
    chk("lone_idle_we3", {31'd0, we3}, 32'd0);

    // Contention: head loses 4 cycles, then one stall cycle commits it
    issue(5'd12);
    pipe_we = 1; pipe_rd = 5'd1; pipe_wd = 32'h101;
    md_valid = 1; md_rd = 5'd12; md_wd = 32'hCAFE;
    #1 chk("cont_pipe_a3_1", {27'd0, a3}, 32'd1);
    tick();
    md_valid = 0;
    for (int k = 1; k <= 4; k++) begin
      pipe_rd = 5'(k + 1); pipe_wd = 32'h100 + 32'(k + 1);
      #1;
      chk("cont_no_stall", {31'd0, stall_req}, 32'd0);
      chk("cont_pipe_a3", {27'd0, a3}, 32'(k + 1));
      tick();
    end
    pipe_rd = 5'd6; pipe_wd = 32'h106;
    #1;
    chk("cont_stall", {31'd0, stall_req}, 32'd1);
    chk("cont_stall_a3", {27'd0, a3}, 32'd12);
    chk("cont_stall_wd3", wd3, 32'hCAFE);
    chk("cont_stall_we3", {31'd0, we3}, 32'd1);
    tick();
    chk("cont_stall_drop", {31'd0, stall_req}, 32'd0);
    chk("cont_resume_a3", {27'd0, a3}, 32'd6);
    chk("cont_resume_wd3", wd3, 32'h106);
    chk("cont_pend_clr", pend_mask, 32'd0);
    tick();
    pipe_we = 0;

    // Full FIFO: two results queued behind pipe traffic, third held until first pop
    issue(5'd20); issue(5'd21); issue(5'd22);
    pipe_we = 1; pipe_rd = 5'd2; pipe_wd = 32'h2;
    md_valid = 1; md_rd = 5'd20; md_wd = 32'hA0;
    #1 chk("full_ready0", {31'd0, md_ready}, 32'd1);
    tick();
    pipe_rd = 5'd3; md_rd = 5'd21; md_wd = 32'hA1;
    #1 chk("full_ready1", {31'd0, md_ready}, 32'd1);
    tick();
    pipe_rd = 5'd4; md_rd = 5'd22; md_wd = 32'hA2;
    #1 chk("full_ready_low", {31'd0, md_ready}, 32'd0);
    tick();
    pipe_we = 0;
    #1;
    chk("full_head0_a3", {27'd0, a3}, 32'd20);
    chk("full_head0_wd3", wd3, 32'hA0);
    chk("full_still_full", {31'd0, md_ready}, 32'd0);
    tick();
    chk("full_ready_after_pop", {31'd0, md_ready}, 32'd1);
    chk("full_head1_a3", {27'd0, a3}, 32'd21);
    tick();
    md_valid = 0;
    #1;
    chk("full_head2_a3", {27'd0, a3}, 32'd22);
    chk("full_head2_wd3", wd3, 32'hA2);
    tick();
    chk("full_drained_we3", {31'd0, we3}, 32'd0);
    chk("full_pend_clr", pend_mask, 32'd0);

    // x0: pipe write to x0 yields the port; md entry with rd=0 pops silently
    issue(5'd9); issue(5'd10);
    md_valid = 1; md_rd = 5'd9; md_wd = 32'h99;
    tick();
    md_valid = 0;
    pipe_we = 1; pipe_rd = 5'd0; pipe_wd = 32'hFFFF;
    #1;
    chk("x0_head_we3", {31'd0, we3}, 32'd1);
    chk("x0_head_a3", {27'd0, a3}, 32'd9);
    chk("x0_head_wd3", wd3, 32'h99);
    tick();
    chk("x0_pipe_no_we3", {31'd0, we3}, 32'd0);
    pipe_we = 0;
    md_valid = 1; md_rd = 5'd0; md_wd = 32'h77;
    tick();
    md_rd = 5'd10; md_wd = 32'h1010;
    #1;
    chk("x0_md_no_we3", {31'd0, we3}, 32'd0);
    chk("x0_md_pend", pend_mask, 32'h0000_0400);
    tick();
    md_valid = 0;
    #1;
    chk("x0_next_a3", {27'd0, a3}, 32'd10);
    chk("x0_next_we3", {31'd0, we3}, 32'd1);
    tick();
    chk("x0_pend_clr", pend_mask, 32'd0);

    // Same-cycle set and clear of x3: set wins
    issue(5'd3);
    md_valid = 1; md_rd = 5'd3; md_wd = 32'h33;
    tick();
    md_valid = 0;
    iss_valid = 1; iss_rd = 5'd3;
    #1 chk("sc_commit_a3", {27'd0, a3}, 32'd3);
    tick();
    iss_valid = 0; iss_rd = 5'd0;
    #1 chk("sc_set_wins", pend_mask, 32'h0000_0008);
    md_valid = 1; md_rd = 5'd3; md_wd = 32'h34;
    tick();
    md_valid = 0;
    tick();
    chk("sc_final_clr", pend_mask, 32'd0);

    // Reset mid-burst with two entries queued
    issue(5'd14); issue(5'd15);
    pipe_we = 1; pipe_rd = 5'd1; pipe_wd = 32'h1;
    md_valid = 1; md_rd = 5'd14; md_wd = 32'hE14;
    tick();
    md_rd = 5'd15; md_wd = 32'hE15;
    tick();
    md_valid = 0;
    #1;
    chk("mid_full", {31'd0, md_ready}, 32'd0);
    chk("mid_pend", pend_mask, 32'h0000_C000);
    pipe_we = 0;
    #2 rstn = 1'b0;
    #1;
    chk("mid_rst_we3", {31'd0, we3}, 32'd0);
    chk("mid_rst_pend", pend_mask, 32'd0);
    chk("mid_rst_ready", {31'd0, md_ready}, 32'd1);
    tick();
    rstn = 1'b1;
    tick();
    chk("post_rst_we3_a", {31'd0, we3}, 32'd0);
    tick();
    chk("post_rst_we3_b", {31'd0, we3}, 32'd0);
    chk("post_rst_a3", {27'd0, a3}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
